// File: rtl/ahb_lite_pkg.sv
// -----------------------------------------------------------------------------
// ahb_lite_pkg
//   Shared AHB-Lite encodings and the copy-engine state type.
//   Contents:
//     HTRANS_IDLE / HTRANS_NONSEQ  - transfer types driven by the copy master
//     HSIZE_WORD                   - 32-bit transfer size
//     HBURST_SINGLE                - single (non-burst) transfers only
//     HPROT_DATA_PRIV              - privileged data access
//     copy_state_t                 - states of the copy sequencer
// -----------------------------------------------------------------------------
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE     = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
   localparam logic [2:0] HSIZE_WORD      = 3'b010;
   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   // RD_A/WR_A are address phases, RD_D/WR_D the matching data phases.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_A,
      ST_WR_D,
      ST_DONE,
      ST_ERR
   } copy_state_t;

endpackage : ahb_lite_pkg

// File: rtl/ahb_copy_master_if.sv
// -----------------------------------------------------------------------------
// ahb_copy_master_if
//   AHB-Lite signal bundle between the copy master and the slave mux.
//   Modports:
//     master - drives HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
//              HWDATA; receives HRDATA, HREADY, HRESP
//     slave  - the mirror image, used by the slave side / bus models
// -----------------------------------------------------------------------------
interface ahb_copy_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [3:0]        HPROT;
   logic              HMASTLOCK;
   logic [DATA_W-1:0] HWDATA;
   logic [DATA_W-1:0] HRDATA;
   logic              HREADY;
   logic              HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HRDATA, HREADY, HRESP
   );

endinterface : ahb_copy_master_if

// File: rtl/ahb_copy_master.sv
// -----------------------------------------------------------------------------
// ahb_copy_master
//   AHB-Lite initiator that copies word_count 32-bit words from src_addr to
//   dst_addr using single, non-pipelined NONSEQ transfers (read, then write,
//   per word). Honours HREADY wait states and the two-cycle HRESP error.
//
//   Ports:
//     sys_clock   in   system clock
//     reset       in   synchronous, active-high reset
//     start       in   launch pulse, only sampled while idle
//     src_addr    in   source byte address (bits [1:0] ignored)
//     dst_addr    in   destination byte address (bits [1:0] ignored)
//     word_count  in   number of words to copy, 0 allowed
//     busy        out  a transfer sequence is in progress
//     done        out  one-cycle completion pulse
//     error       out  sticky bus-error flag, cleared by the next start
//     words_left  out  words still to be copied
//     ahb         AHB-Lite master modport (DATA_W must be 32)
// -----------------------------------------------------------------------------
module ahb_copy_master
   import ahb_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              sys_clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [LEN_W-1:0]  word_count,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [LEN_W-1:0]  words_left,
   ahb_copy_master_if.master ahb
);

   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
   localparam logic [LEN_W-1:0]  ONE_WORD  = LEN_W'(1);

   copy_state_t       state, state_nxt;

   logic [ADDR_W-1:0] src_q, src_nxt;
   logic [ADDR_W-1:0] dst_q, dst_nxt;
   logic [LEN_W-1:0]  cnt_q, cnt_nxt;
   logic [DATA_W-1:0] buf_q, buf_nxt;
   logic              error_q, error_nxt;

   logic [ADDR_W-1:0] haddr_q, haddr_nxt;
   logic [1:0]        htrans_q, htrans_nxt;
   logic              hwrite_q, hwrite_nxt;
   logic [DATA_W-1:0] hwdata_q, hwdata_nxt;

   // A data phase ends cleanly when the slave is ready and not signalling error.
   logic              phase_ok;
   assign phase_ok = ahb.HREADY & ~ahb.HRESP;

   // Only whole words are moved; the byte-offset bits of the inputs are dropped.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge sys_clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch forms.
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = (word_count == '0) ? ST_DONE : ST_RD_A;
         end
         ST_RD_A: begin
            if (ahb.HREADY) state_nxt = ST_RD_D;
         end
         ST_RD_D: begin
            // Leave on the first HRESP cycle; the second one lands in ERR.
            if (ahb.HRESP)       state_nxt = ST_ERR;
            else if (ahb.HREADY) state_nxt = ST_WR_A;
         end
         ST_WR_A: begin
            if (ahb.HREADY) state_nxt = ST_WR_D;
         end
         ST_WR_D: begin
            if (ahb.HRESP)       state_nxt = ST_ERR;
            else if (ahb.HREADY) state_nxt = (cnt_q == ONE_WORD) ? ST_DONE : ST_RD_A;
         end
         ST_DONE: state_nxt = ST_IDLE;
         ST_ERR:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Copy datapath: pointers, word counter, read buffer, sticky error
   // --------------------------------------------------------------------------
   always_comb begin
      src_nxt   = src_q;
      dst_nxt   = dst_q;
      cnt_nxt   = cnt_q;
      buf_nxt   = buf_q;
      error_nxt = error_q;
      case (state)
         ST_IDLE: begin
            if (start) begin
               src_nxt   = {src_addr[ADDR_W-1:2], 2'b00};
               dst_nxt   = {dst_addr[ADDR_W-1:2], 2'b00};
               cnt_nxt   = word_count;
               error_nxt = 1'b0;
            end
         end
         ST_RD_D: begin
            if (phase_ok) buf_nxt = ahb.HRDATA;
         end
         ST_WR_D: begin
            // Pointer wrap at 2^ADDR_W is intended.
            if (phase_ok) begin
               src_nxt = src_q + WORD_STEP;
               dst_nxt = dst_q + WORD_STEP;
               cnt_nxt = cnt_q - ONE_WORD;
            end
         end
         ST_ERR:  error_nxt = 1'b1;
         default: ;
      endcase
   end

   // --------------------------------------------------------------------------
   // AHB drive, decoded from the state being entered so the registered bus
   // outputs line up with the state register. Address and write enable are
   // only reloaded when an address phase starts, so they hold through waits.
   // --------------------------------------------------------------------------
   always_comb begin
      haddr_nxt  = haddr_q;
      htrans_nxt = HTRANS_IDLE;
      hwrite_nxt = hwrite_q;
      hwdata_nxt = hwdata_q;
      case (state_nxt)
         ST_RD_A: begin
            haddr_nxt  = src_nxt;
            htrans_nxt = HTRANS_NONSEQ;
            hwrite_nxt = 1'b0;
         end
         ST_WR_A: begin
            haddr_nxt  = dst_nxt;
            htrans_nxt = HTRANS_NONSEQ;
            hwrite_nxt = 1'b1;
         end
         // buf_q is frozen for the whole write, so HWDATA stays stable in waits.
         ST_WR_D: hwdata_nxt = buf_q;
         default: ;
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath and bus registers
   // --------------------------------------------------------------------------
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         src_q    <= '0;
         dst_q    <= '0;
         cnt_q    <= '0;
         buf_q    <= '0;
         error_q  <= 1'b0;
         haddr_q  <= '0;
         htrans_q <= HTRANS_IDLE;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
      end else begin
         src_q    <= src_nxt;
         dst_q    <= dst_nxt;
         cnt_q    <= cnt_nxt;
         buf_q    <= buf_nxt;
         error_q  <= error_nxt;
         haddr_q  <= haddr_nxt;
         htrans_q <= htrans_nxt;
         hwrite_q <= hwrite_nxt;
         hwdata_q <= hwdata_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign busy       = (state == ST_RD_A) || (state == ST_RD_D) ||
                       (state == ST_WR_A) || (state == ST_WR_D);
   assign done       = (state == ST_DONE);
   assign error      = error_q;
   assign words_left = cnt_q;

   assign ahb.HADDR     = haddr_q;
   assign ahb.HTRANS    = htrans_q;
   assign ahb.HWRITE    = hwrite_q;
   assign ahb.HWDATA    = hwdata_q;
   assign ahb.HSIZE     = HSIZE_WORD;
   assign ahb.HBURST    = HBURST_SINGLE;
   assign ahb.HPROT     = HPROT_DATA_PRIV;
   assign ahb.HMASTLOCK = 1'b0;

endmodule : ahb_copy_master

// File: doc/ahb_copy_master.md
Name: ahb_copy_master

Overview:
- AHB-Lite initiator that copies a block of 32-bit words from a source address to a destination address on the data-side bus.
- Sits beside the core as a second bus master, in front of the address decoder and slave mux. It drives the same slaves (memory cache, UART, keys, timer) that the core uses.
- Serves boot-image relocation and test-pattern fills without involving the CPU.
- Issues single, non-pipelined word transfers. It honours HREADY wait states and the two-cycle HRESP error response.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width; only 32 is supported.
- LEN_W, 16, width of the word-count register.

Ports:
- sys_clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse that launches a copy; sampled only in IDLE.
- src_addr  in  ADDR_W  source byte address; bits [1:0] are ignored.
- dst_addr  in  ADDR_W  destination byte address; bits [1:0] are ignored.
- word_count  in  LEN_W  number of words to copy; 0 is legal.
- busy  out  1  high from the cycle after an accepted start until DONE/ERR exits.
- done  out  1  one-cycle pulse when the copy completes.
- error  out  1  sticky bus-error flag; cleared by the next accepted start.
- words_left  out  LEN_W  remaining words to copy.
- HADDR  out  ADDR_W  AHB address.
- HTRANS  out  2  AHB transfer type; only IDLE=00 and NONSEQ=10 are used.
- HWRITE  out  1  AHB write enable.
- HSIZE  out  3  AHB transfer size; constant 010 (word).
- HBURST  out  3  AHB burst type; constant 000 (SINGLE).
- HPROT  out  4  AHB protection; constant 0011.
- HMASTLOCK  out  1  AHB lock; constant 0.
- HWDATA  out  DATA_W  AHB write data.
- HRDATA  in  DATA_W  AHB read data.
- HREADY  in  1  AHB ready from the slave mux.
- HRESP  in  1  AHB error response.

Behaviour:
- Reset values of outputs:
  - busy=0, done=0, error=0, words_left=0.
  - HADDR=0, HTRANS=IDLE, HWRITE=0, HWDATA=0.
- On reset, the FSM goes to IDLE and the internal src, dst, cnt and buf registers clear.
- Reset during an operation abandons the transfer immediately; HTRANS=IDLE on the next cycle.
- FSM states: IDLE, RD_A, RD_D, WR_A, WR_D, DONE, ERR.
- IDLE:
  - On start: latch src={src_addr[31:2],00}, dst likewise, cnt=word_count; clear error.
  - If word_count==0, go to DONE; otherwise go to RD_A.
  - start asserted in any other state is ignored.
- RD_A:
  - Drive HADDR=src, HTRANS=NONSEQ, HWRITE=0.
  - Hold all three while HREADY=0.
  - On HREADY=1, go to RD_D.
- RD_D:
  - Drive HTRANS=IDLE.
  - On HREADY=1 with HRESP=0: buf<=HRDATA, then go to WR_A.
  - On HRESP=1 (either cycle of the error response): go to ERR.
- WR_A:
  - Drive HADDR=dst, HTRANS=NONSEQ, HWRITE=1.
  - Hold while HREADY=0.
  - On HREADY=1, go to WR_D.
- WR_D:
  - Drive HWDATA=buf, held stable for the whole data phase; HTRANS=IDLE.
  - On HREADY=1 with HRESP=0:
    - src+=4, dst+=4, cnt-=1.
    - If the new cnt==0, go to DONE; otherwise go to RD_A.
  - On HRESP=1: go to ERR.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- ERR: error<=1 (sticky), busy=0, done stays 0, then go to IDLE. cnt keeps the count remaining at the fault.
- Latency: with zero-wait slaves, 4 cycles per word. Total from start to done = 4*N+2 cycles (start cycle, then 4N, then DONE).
- Address arithmetic is modulo 2^ADDR_W: 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- Overlapping src and dst ranges are copied in ascending order; no overlap protection.
- words_left reflects cnt every cycle.

Decomposition:
- Shared package ahb_lite_pkg holds:
  - HTRANS_IDLE, HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE, HPROT_DATA_PRIV constants.
  - The copy_state_t enum.
- Single module, no sub-module. The AHB output drive is a registered decode of the state, kept inside the same module.

Test Plan:
- Zero-wait slave model; memory at 0x1C010000 holds 0x11111111, 0x22222222, 0x33333333; start with src=0x1C010000, dst=0x1C020000, count=3 -> three reads then three writes of those values to 0x1C020000/04/08; done pulses at cycle 14 after start; error=0.
- Slave inserts 2 wait states on every phase -> HADDR/HTRANS/HWRITE held stable during waits; HWDATA held through the write data phase; copied data identical to the zero-wait case.
- HRESP error response (cycle 1 HRESP=1/HREADY=0, cycle 2 HRESP=1/HREADY=1) on the second read, count=4 -> ERR; error=1; no write to dst+4; words_left=3; done never pulses; a new start clears error.
- Count=0 -> HTRANS stays IDLE throughout; done pulses 2 cycles after start.
- src=0xFFFFFFFC, count=2 -> second read address is 0x00000000.
- src=0x1C010003 -> first HADDR is 0x1C010000.
- start pulsed while busy -> ignored; reset asserted in WR_A -> next cycle HTRANS=IDLE, busy=0, FSM in IDLE.
